uart_txrx_param: RTL and testbench

Parametrised full-duplex UART transceiver for the CH340 link. It is the generalised successor of the fixed 8N1 test transceiver. Data width, parity, stop bits and baud rate are all compile-time selectable. The TX side uses a valid/ready handshake, and the RX side has majority-vote sampling, false-start rejection and error flags. It sits between user logic (key/command FSMs) and the board tx/rx pins.

---
 rtl/uart_txrx_param_if.sv | 22 ++
 rtl/uart_txrx_param.sv | 156 +++++++++++++++
 tb/tb_uart_txrx_param.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_txrx_param_if.sv
// rtl/uart_txrx_param_if.sv - user-side handshake bundle for uart_txrx_param
interface uart_txrx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_txrx_param.sv
// rtl/uart_txrx_param.sv - parametrised full-duplex UART with majority-vote RX
module uart_txrx_param #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic               sclk,
  input  logic               nrst,
  uart_txrx_param_if.slave   bus,
  output logic               tx,
  input  logic               rx
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(STOP_BITS * DIV + 1);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [CW-1:0] MID_A    = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] MID_B    = CW'(DIV / 2);
  localparam logic [CW-1:0] MID_C    = CW'(DIV / 2 + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               tx_st, tx_nxt;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_pbit;
  logic                 tx_last;
  logic                 tx_accept;

  assign tx_last   = (tx_st == S_STOP) ? (tx_cnt == STOP_END) : (tx_cnt == BIT_END);
  assign tx_accept = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      tx_st   <= S_IDLE;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sh   <= '0;
      tx_pbit <= 1'b0;
    end else begin
      tx_st  <= tx_nxt;
      tx_cnt <= (tx_st == S_IDLE || tx_st != tx_nxt || tx_last) ? '0 : tx_cnt + 1'b1;
      if (tx_accept) begin
        tx_sh   <= bus.tx_data;
        tx_pbit <= (^bus.tx_data) ^ ODD;
        tx_idx  <= '0;
      end else if (tx_st == S_DATA && tx_last) begin
        tx_sh  <= tx_sh >> 1;
        tx_idx <= tx_idx + 1'b1;
      end
    end
  end

  always_comb begin
    tx_nxt = tx_st;
    case (tx_st)
      S_IDLE:  if (bus.tx_valid) tx_nxt = S_START;
      S_START: if (tx_last) tx_nxt = S_DATA;
      S_DATA:  if (tx_last && tx_idx == LAST_IDX) tx_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (tx_last) tx_nxt = S_STOP;
      S_STOP:  if (tx_last) tx_nxt = bus.tx_valid ? S_START : S_IDLE;
      default: tx_nxt = S_IDLE;
    endcase
  end

  // Ready on the final stop cycle lets a queued frame start with no idle gap.
  always_comb begin
    bus.tx_ready = (tx_st == S_IDLE) || (tx_st == S_STOP && tx_last);
    case (tx_st)
      S_START: tx = 1'b0;
      S_DATA:  tx = tx_sh[0];
      S_PAR:   tx = tx_pbit;
      default: tx = 1'b1;
    endcase
  end

  logic                 rx_s1, rx_s2, rx_s3;
  state_t               rx_st, rx_nxt;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 smp_a, smp_b;
  logic                 rx_maj, rx_fall, rx_last, rx_mid;
  logic                 rx_take, rx_pchk, rx_done;
  logic                 perr_r;

  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_last = (rx_cnt == BIT_END);
  assign rx_mid  = (rx_cnt == MID_C);
  assign rx_maj  = (smp_a & smp_b) | (smp_a & rx_s2) | (smp_b & rx_s2);

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      rx_s1             <= 1'b1;
      rx_s2             <= 1'b1;
      rx_s3             <= 1'b1;
      rx_st             <= S_IDLE;
      rx_cnt            <= '0;
      rx_idx            <= '0;
      rx_sh             <= '0;
      smp_a             <= 1'b1;
      smp_b             <= 1'b1;
      perr_r            <= 1'b0;
      bus.rx_data       <= '0;
      bus.rx_valid      <= 1'b0;
      bus.rx_parity_err <= 1'b0;
      bus.rx_frame_err  <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      rx_st  <= rx_nxt;
      rx_cnt <= (rx_st == S_IDLE || rx_st != rx_nxt || rx_last) ? '0 : rx_cnt + 1'b1;
      if (rx_cnt == MID_A) smp_a <= rx_s2;
      if (rx_cnt == MID_B) smp_b <= rx_s2;
      if (rx_st == S_IDLE) rx_idx <= '0;
      else if (rx_st == S_DATA && rx_last) rx_idx <= rx_idx + 1'b1;
      if (rx_take) rx_sh <= {rx_maj, rx_sh[DATA_BITS-1:1]};
      if (rx_pchk) perr_r <= rx_maj ^ (^rx_sh) ^ ODD;
      bus.rx_valid <= rx_done;
      if (rx_done) begin
        bus.rx_data       <= rx_sh;
        bus.rx_parity_err <= perr_r;
        bus.rx_frame_err  <= ~rx_maj;
      end
    end
  end

  // Leaving STOP at mid-bit gives slack for baud mismatch and back-to-back frames.
  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      S_IDLE:  if (rx_fall) rx_nxt = S_START;
      S_START: begin
        if (rx_mid && rx_maj) rx_nxt = S_IDLE;
        else if (rx_last) rx_nxt = S_DATA;
      end
      S_DATA:  if (rx_last && rx_idx == LAST_IDX) rx_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (rx_last) rx_nxt = S_STOP;
      S_STOP:  if (rx_mid) rx_nxt = S_IDLE;
      default: rx_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_take = (rx_st == S_DATA) && rx_mid;
    rx_pchk = (rx_st == S_PAR) && rx_mid;
    rx_done = (rx_st == S_STOP) && rx_mid;
  end
endmodule

// File: tb/tb_uart_txrx_param.sv
// tb/tb_uart_txrx_param.sv - directed bench for uart_txrx_param
module tb_uart_txrx_param;
  logic sclk;
  logic nrst;
  logic tx0, tx1, tx2;
  logic rx0, rx2;
  int   vecs;
  int   errs;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  uart_txrx_param_if #(.DATA_BITS(8)) if0 ();
  uart_txrx_param_if #(.DATA_BITS(8)) if1 ();
  uart_txrx_param_if #(.DATA_BITS(8)) if2 ();

  uart_txrx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .sclk(sclk), .nrst(nrst), .bus(if0), .tx(tx0), .rx(rx0));
  uart_txrx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u1 (
    .sclk(sclk), .nrst(nrst), .bus(if1), .tx(tx1), .rx(tx1));
  uart_txrx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .sclk(sclk), .nrst(nrst), .bus(if2), .tx(tx2), .rx(rx2));

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  always @(negedge sclk) begin
    if (if0.rx_valid) q0.push_back({if0.rx_parity_err, if0.rx_frame_err, if0.rx_data});
    if (if1.rx_valid) q1.push_back({if1.rx_parity_err, if1.rx_frame_err, if1.rx_data});
    if (if2.rx_valid) q2.push_back({if2.rx_parity_err, if2.rx_frame_err, if2.rx_data});
  end

  // 8N1 line level k cycles after the accepting edge, DIV=10.
  function automatic logic exp_8n1(input logic [7:0] d, input int k);
    if (k >= 1 && k <= 10) return 1'b0;
    if (k >= 11 && k <= 90) return d[(k - 11) / 10];
    return 1'b1;
  endfunction

  task automatic put_rx(input int d, input logic v);
    if (d == 0) rx0 = v;
    else rx2 = v;
  endtask

  task automatic drive_rx(input int d, input logic [7:0] data, input logic use_par,
                          input logic par, input logic stop, input logic spike);
    int n;
    n = use_par ? 11 : 10;
    for (int b = 0; b < n; b++) begin
      logic v;
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = data[b-1];
      else if (use_par && b == 9) v = par;
      else v = stop;
      for (int c = 0; c < 10; c++) begin
        @(posedge sclk); #1;
        put_rx(d, (spike && b >= 1 && b <= 8 && c == 5) ? ~v : v);
      end
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    vecs++; if (tx0 !== 1'b1) begin errs++; $display("FAIL reset_tx: got %b want 1", tx0); end
    vecs++; if (if0.tx_ready !== 1'b1) begin errs++; $display("FAIL reset_tx_ready: got %b want 1", if0.tx_ready); end
    vecs++; if (if0.rx_data !== 8'h00) begin errs++; $display("FAIL reset_rx_data: got %h want 00", if0.rx_data); end
    vecs++; if (if0.rx_valid !== 1'b0) begin errs++; $display("FAIL reset_rx_valid: got %b want 0", if0.rx_valid); end
    vecs++; if (if0.rx_parity_err !== 1'b0) begin errs++; $display("FAIL reset_perr: got %b want 0", if0.rx_parity_err); end
    vecs++; if (if0.rx_frame_err !== 1'b0) begin errs++; $display("FAIL reset_ferr: got %b want 0", if0.rx_frame_err); end
    vecs++; if (tx1 !== 1'b1) begin errs++; $display("FAIL reset_tx1: got %b want 1", tx1); end
    @(posedge sclk); #1 nrst = 1'b1;
    repeat (5) @(posedge sclk);
  endtask

  task automatic test_tx_8n1;
    @(negedge sclk);
    if0.tx_data = 8'hA5;
    if0.tx_valid = 1'b1;
    @(posedge sclk); #1 if0.tx_valid = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      @(negedge sclk);
      vecs++;
      if (tx0 !== exp_8n1(8'hA5, k)) begin
        errs++; $display("FAIL tx_8n1_line cycle %0d: got %b want %b", k, tx0, exp_8n1(8'hA5, k));
      end
      vecs++;
      if (if0.tx_ready !== (k >= 100)) begin
        errs++; $display("FAIL tx_8n1_ready cycle %0d: got %b want %b", k, if0.tx_ready, (k >= 100));
      end
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    logic [9:0] exp_q [2];
    exp_q[0] = {2'b00, 8'h3C};
    exp_q[1] = {2'b00, 8'hFF};
    q1.delete();
    gap = 0;
    @(negedge sclk);
    if1.tx_data = 8'h3C;
    if1.tx_valid = 1'b1;
    @(posedge sclk); #1 if1.tx_data = 8'hFF;
    for (int k = 1; k <= 200 && gap == 0; k++) begin
      @(negedge sclk);
      if (if1.tx_ready) gap = k;
    end
    @(posedge sclk); #1 if1.tx_valid = 1'b0;
    vecs++;
    if (gap !== 120) begin errs++; $display("FAIL b2b_gap: got %0d want 120", gap); end
    repeat (160) @(posedge sclk);
    vecs++;
    if (q1.size() !== 2) begin errs++; $display("FAIL b2b_count: got %0d want 2", q1.size()); end
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if (q1.size() <= i || q1[i] !== exp_q[i]) begin
        errs++; $display("FAIL b2b_frame%0d: got %h want %h", i, (q1.size() > i) ? q1[i] : 10'h3FF, exp_q[i]);
      end
    end
  endtask

  task automatic test_parity_err;
    q2.delete();
    drive_rx(2, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_rx(2, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (20) @(posedge sclk);
    vecs++;
    if (q2.size() !== 2) begin errs++; $display("FAIL parity_count: got %0d want 2", q2.size()); end
    vecs++;
    if (q2.size() < 1 || q2[0] !== {1'b1, 1'b0, 8'h01}) begin
      errs++; $display("FAIL parity_bad: got %h want %h", (q2.size() > 0) ? q2[0] : 10'h3FF, {1'b1, 1'b0, 8'h01});
    end
    vecs++;
    if (q2.size() < 2 || q2[1] !== {1'b0, 1'b0, 8'h01}) begin
      errs++; $display("FAIL parity_good: got %h want %h", (q2.size() > 1) ? q2[1] : 10'h3FF, {1'b0, 1'b0, 8'h01});
    end
  endtask

  task automatic test_glitch_frame;
    q0.delete();
    @(posedge sclk); #1 rx0 = 1'b0;
    repeat (3) @(posedge sclk);
    #1 rx0 = 1'b1;
    repeat (30) @(posedge sclk);
    vecs++;
    if (q0.size() !== 0) begin errs++; $display("FAIL glitch_reject: got %0d pulses want 0", q0.size()); end
    drive_rx(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (200) @(posedge sclk);
    vecs++;
    if (q0.size() !== 1) begin errs++; $display("FAIL frame_count: got %0d want 1", q0.size()); end
    vecs++;
    if (q0.size() < 1 || q0[0] !== {1'b0, 1'b1, 8'h55}) begin
      errs++; $display("FAIL frame_err: got %h want %h", (q0.size() > 0) ? q0[0] : 10'h3FF, {1'b0, 1'b1, 8'h55});
    end
    #1 rx0 = 1'b1;
    repeat (20) @(posedge sclk);
  endtask

  task automatic test_majority;
    q0.delete();
    drive_rx(0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge sclk);
    vecs++;
    if (q0.size() !== 1) begin errs++; $display("FAIL majority_count: got %0d want 1", q0.size()); end
    vecs++;
    if (q0.size() < 1 || q0[0] !== {2'b00, 8'h80}) begin
      errs++; $display("FAIL majority_data: got %h want %h", (q0.size() > 0) ? q0[0] : 10'h3FF, {2'b00, 8'h80});
    end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge sclk);
    if0.tx_data = 8'h00;
    if0.tx_valid = 1'b1;
    @(posedge sclk); #1 if0.tx_valid = 1'b0;
    repeat (44) @(posedge sclk);
    #1;
    vecs++;
    if (tx0 !== 1'b0) begin errs++; $display("FAIL midrst_before: got %b want 0", tx0); end
    nrst = 1'b0;
    #2;
    vecs++;
    if (tx0 !== 1'b1) begin errs++; $display("FAIL midrst_tx: got %b want 1", tx0); end
    vecs++;
    if (if0.tx_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready: got %b want 1", if0.tx_ready); end
    repeat (3) @(posedge sclk);
    #1 nrst = 1'b1;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    if0.tx_data = 8'h12;
    if0.tx_valid = 1'b1;
    @(posedge sclk); #1 if0.tx_valid = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      @(negedge sclk);
      vecs++;
      if (tx0 !== exp_8n1(8'h12, k)) begin
        errs++; $display("FAIL midrst_frame cycle %0d: got %b want %b", k, tx0, exp_8n1(8'h12, k));
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    nrst = 1'b1;
    rx0 = 1'b1;
    rx2 = 1'b1;
    if0.tx_data = '0; if0.tx_valid = 1'b0;
    if1.tx_data = '0; if1.tx_valid = 1'b0;
    if2.tx_data = '0; if2.tx_valid = 1'b0;
    #1;
    test_reset;
    test_tx_8n1;
    test_back_to_back;
    test_parity_err;
    test_glitch_frame;
    test_majority;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
